// File: rtl/md_cart_pkg.sv
// Shared definitions for the cartridge bank mapper: register offsets,
// address split widths and the request FSM state encoding.
package md_cart_pkg;
  localparam logic [6:0] MAP_SRAM_REG  = 7'h78;
  localparam logic [6:0] MAP_BANK_BASE = 7'h79;
  localparam int SLOT_W       = 3;
  localparam int SLOT_WORDS_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } md_state_t;
endpackage

// File: rtl/md_cart_bankregs.sv
// Mapper register file written through the /TIME window, plus the
// combinational cart-address to memory-address translation.
module md_cart_bankregs
  import md_cart_pkg::*;
#(
  parameter int BANK_W  = 6,
  parameter bit SRAM_EN = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [20:0]                    va_i,
  input  logic [BANK_W-1:0]              vd_i,
  input  logic                           time_n_i,
  input  logic                           lwr_n_i,
  output logic [BANK_W+SLOT_WORDS_W-1:0] map_addr_o,
  output logic                           map_sram_o
);
  // Slot 0 is hard-wired to bank 0, so only slots 1..7 have storage.
  logic [BANK_W-1:0] bank_q [7];
  logic              sram_on_q;
  logic              lwr_q;
  logic              reg_wr;
  logic [SLOT_W-1:0] slot;
  logic [BANK_W-1:0] bank_sel;

  assign reg_wr = ~time_n_i & lwr_q & ~lwr_n_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lwr_q     <= 1'b1;
      sram_on_q <= 1'b0;
      for (int i = 0; i < 7; i++) bank_q[i] <= BANK_W'(i + 1);
    end else begin
      lwr_q <= lwr_n_i;
      if (reg_wr) begin
        if (va_i[6:0] == MAP_SRAM_REG)
          sram_on_q <= vd_i[0] & SRAM_EN;
        else if (va_i[6:0] >= MAP_BANK_BASE)
          bank_q[va_i[2:0] - 3'd1] <= vd_i;
      end
    end
  end

  always_comb begin
    slot       = va_i[20:18];
    bank_sel   = (slot == '0) ? '0 : bank_q[slot - 3'd1];
    map_sram_o = sram_on_q & va_i[20];
    map_addr_o = map_sram_o ? {{BANK_W{1'b0}}, va_i[17:0]} : {bank_sel, va_i[17:0]};
  end
endmodule

// File: rtl/md_cart_mapper.sv
// 68k cart bus to word-wide memory bridge with bank mapping, optional SRAM
// window and a req/ack handshake bounded by a latency timeout.
module md_cart_mapper
  import md_cart_pkg::*;
#(
  parameter int BANK_W  = 6,
  parameter int TIMEOUT = 24,
  parameter bit SRAM_EN = 1'b1
) (
  input  logic                           MCLK,
  input  logic                           ext_reset,
  input  logic [22:0]                    VA,
  input  logic [15:0]                    VD_i,
  input  logic                           CE0,
  input  logic                           CAS0,
  input  logic                           LWR,
  input  logic                           UWR,
  input  logic                           TIME,
  output logic [15:0]                    cart_VD_o,
  output logic                           cart_VD_d,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [1:0]                     mem_be,
  output logic [BANK_W+SLOT_WORDS_W-1:0] mem_addr,
  output logic                           mem_sram,
  output logic [15:0]                    mem_wdata,
  input  logic                           mem_ack,
  input  logic [15:0]                    mem_rdata,
  output logic                           late_err,
  output logic [1:0]                     dbg_state_o
);
  localparam int AW    = BANK_W + SLOT_WORDS_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Handshake: mem_req rises when the FSM leaves REQ and stays high until the
  // cycle mem_ack is sampled in WAIT (or the timeout fires); mem_ack is a
  // single-cycle strobe qualifying mem_rdata and is ignored in any other state.

  logic [AW-1:0]    map_addr;
  logic             map_sram;
  logic             rd_sel, wr_sel, sel, start;
  logic             sel_q;
  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d, drop_q, drop_d;
  logic             req_q, req_d, we_q, we_d, sram_q, sram_d;
  logic             vd_d_q, vd_d_d, late_q, late_d;
  logic [1:0]       be_q, be_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d, data_q, data_d, vd_o_q, vd_o_d;
  logic [1:0]       unused_va;

  assign unused_va = VA[22:21];

  md_cart_bankregs #(.BANK_W(BANK_W), .SRAM_EN(SRAM_EN)) u_bankregs (
    .clk_i      (MCLK),
    .rst_i      (ext_reset),
    .va_i       (VA[20:0]),
    .vd_i       (VD_i[BANK_W-1:0]),
    .time_n_i   (TIME),
    .lwr_n_i    (LWR),
    .map_addr_o (map_addr),
    .map_sram_o (map_sram)
  );

  assign rd_sel = ~CE0 & ~CAS0;
  assign wr_sel = ~CE0 & map_sram & ~(LWR & UWR);
  assign sel    = rd_sel | wr_sel;
  assign start  = sel & ~sel_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    sram_d  = sram_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    vd_o_d  = vd_o_q;
    vd_d_d  = 1'b1;
    late_d  = 1'b0;
    if (start && state_q != IDLE) pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start || (pend_q && sel)) begin
          state_d = REQ;
          addr_d  = map_addr;
          sram_d  = map_sram;
          we_d    = ~rd_sel;
          be_d    = rd_sel ? 2'b11 : {~UWR, ~LWR};
          wdata_d = VD_i;
          drop_d  = 1'b0;
        end
      end
      REQ: begin
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
        if (!sel) drop_d = 1'b1;
      end
      WAIT: begin
        // A cycle abandoned by the 68k still finishes its handshake, but the
        // returned data must never reach the bus.
        if (!sel) drop_d = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = HOLD;
          if (!we_q) data_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          data_d  = 16'hFFFF;
          late_d  = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!sel || drop_q) begin
          state_d = IDLE;
        end else if (!we_q) begin
          vd_d_d = 1'b0;
          vd_o_d = data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or posedge ext_reset) begin
    if (ext_reset) begin
      sel_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= '0;
      sram_q  <= 1'b0;
      wdata_q <= 16'h0000;
      data_q  <= 16'hFFFF;
      vd_o_q  <= 16'hFFFF;
      vd_d_q  <= 1'b1;
      late_q  <= 1'b0;
    end else begin
      sel_q   <= sel;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      sram_q  <= sram_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      vd_o_q  <= vd_o_d;
      vd_d_q  <= vd_d_d;
      late_q  <= late_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_be      = be_q;
  assign mem_addr    = addr_q;
  assign mem_sram    = sram_q;
  assign mem_wdata   = wdata_q;
  assign cart_VD_o   = vd_o_q;
  assign cart_VD_d   = vd_d_q;
  assign late_err    = late_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_md_cart_mapper.sv
// Directed bench for md_cart_mapper: request and read-data scoreboards fed by
// the driver tasks and drained by an independent monitor.
`timescale 1ns/1ps
module tb_md_cart_mapper;
  import md_cart_pkg::*;

  localparam int REQ_W = 44;

  logic        MCLK, ext_reset;
  logic [22:0] VA;
  logic [15:0] VD_i, cart_VD_o, mem_wdata, mem_rdata;
  logic        CE0, CAS0, LWR, UWR, TIME;
  logic        cart_VD_d, mem_req, mem_we, mem_sram, mem_ack, late_err;
  logic [1:0]  mem_be, dbg_state;
  logic [23:0] mem_addr;

  logic [REQ_W-1:0] req_exp_q[$];
  logic [15:0]      rd_exp_q[$];
  int tests, fails, late_cnt;

  md_cart_mapper dut (
    .MCLK(MCLK), .ext_reset(ext_reset), .VA(VA), .VD_i(VD_i), .CE0(CE0),
    .CAS0(CAS0), .LWR(LWR), .UWR(UWR), .TIME(TIME), .cart_VD_o(cart_VD_o),
    .cart_VD_d(cart_VD_d), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_sram(mem_sram), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .late_err(late_err),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or drives VD
  initial begin
    logic req_prev, vdd_prev;
    req_prev = 1'b0;
    vdd_prev = 1'b1;
    forever begin
      @(posedge MCLK);
      #1;
      if (!ext_reset) begin
        if (mem_req && !req_prev) begin
          if (req_exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_req: got addr %0h with no expected request", mem_addr);
          end else begin
            check("req_fields", 64'({mem_addr, mem_sram, mem_we, mem_be, mem_wdata}),
                  64'(req_exp_q.pop_front()));
          end
        end
        if (!cart_VD_d && vdd_prev) begin
          if (rd_exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_drive: got VD %0h with no expected read data", cart_VD_o);
          end else begin
            check("rd_data", 64'(cart_VD_o), 64'(rd_exp_q.pop_front()));
          end
        end
        if (late_err) late_cnt++;
      end
      req_prev = mem_req;
      vdd_prev = cart_VD_d;
    end
  end

  // Driver tasks
  task automatic bus_idle();
    CE0 = 1'b1; CAS0 = 1'b1; LWR = 1'b1; UWR = 1'b1; TIME = 1'b1;
  endtask

  task automatic reg_write(input logic [6:0] addr, input logic [15:0] data);
    @(negedge MCLK);
    VA = {16'h0000, addr}; VD_i = data; TIME = 1'b0; LWR = 1'b0;
    repeat (2) @(negedge MCLK);
    LWR = 1'b1; TIME = 1'b1;
    @(negedge MCLK);
  endtask

  task automatic start_read(input logic [22:0] va, input logic [23:0] exp_addr);
    @(negedge MCLK);
    VA = va; VD_i = 16'h0000; CE0 = 1'b0; CAS0 = 1'b0;
    req_exp_q.push_back({exp_addr, 1'b0, 1'b0, 2'b11, 16'h0000});
  endtask

  task automatic wait_req(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge MCLK);
    end
    check(name, 64'(seen), 64'(1));
  endtask

  task automatic ack_read(input logic [15:0] rdata, output int lat);
    mem_rdata = rdata; mem_ack = 1'b1;
    @(negedge MCLK);
    mem_ack = 1'b0; lat = 1;
    while (cart_VD_d && lat < 20) begin
      @(negedge MCLK);
      lat++;
    end
  endtask

  task automatic ack_pulse(input logic [15:0] rdata);
    mem_rdata = rdata; mem_ack = 1'b1;
    @(negedge MCLK);
    mem_ack = 1'b0;
  endtask

  task automatic release_bus(input string name);
    @(negedge MCLK);
    bus_idle();
    @(negedge MCLK);
    check(name, 64'({cart_VD_d, dbg_state}), 64'({1'b1, IDLE}));
  endtask

  initial begin
    int lat, n, n_idle, n_req;
    tests = 0; fails = 0; late_cnt = 0;
    ext_reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
    VA = '0; VD_i = '0;
    bus_idle();
    repeat (3) @(negedge MCLK);
    check("reset_outputs",
          64'({mem_req, mem_we, mem_be, mem_addr, mem_sram, mem_wdata, cart_VD_o, cart_VD_d, late_err}),
          64'({1'b0, 1'b0, 2'b00, 24'h000000, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0}));
    ext_reset = 1'b0;
    repeat (2) @(negedge MCLK);

    // Slot 1 read, ack after 3 cycles
    start_read(23'h040000, 24'h040000);
    rd_exp_q.push_back(16'h1234);
    wait_req("req_seen_slot1");
    repeat (3) @(negedge MCLK);
    ack_read(16'h1234, lat);
    check("rd_latency_slot1", 64'(lat), 64'(2));
    release_bus("release_slot1");

    // Program bank 7, read through slot 7
    reg_write(7'h7F, 16'h002A);
    start_read(23'h1C0005, {6'h2A, 18'h00005});
    rd_exp_q.push_back(16'hBEEF);
    wait_req("req_seen_bank7");
    @(negedge MCLK);
    ack_read(16'hBEEF, lat);
    check("rd_latency_bank7", 64'(lat), 64'(2));
    release_bus("release_bank7");

    // SRAM window low-byte write
    reg_write(7'h78, 16'h0001);
    @(negedge MCLK);
    VA = 23'h100010; VD_i = 16'h00AB; CE0 = 1'b0; UWR = 1'b1; LWR = 1'b0;
    req_exp_q.push_back({24'h000010, 1'b1, 1'b1, 2'b01, 16'h00AB});
    wait_req("req_seen_sram_wr");
    @(negedge MCLK);
    ack_pulse(16'h7777);
    repeat (3) @(negedge MCLK);
    release_bus("release_sram_wr");

    // Same write with the SRAM window off must not reach memory
    reg_write(7'h78, 16'h0000);
    @(negedge MCLK);
    VA = 23'h100010; VD_i = 16'h00AB; CE0 = 1'b0; UWR = 1'b1; LWR = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge MCLK);
      if (mem_req) n++;
    end
    check("rom_write_no_req", 64'(n), 64'(0));
    release_bus("release_rom_wr");

    // Timeout: ack withheld
    check("late_none_before", 64'(late_cnt), 64'(0));
    start_read(23'h000100, 24'h000100);
    rd_exp_q.push_back(16'hFFFF);
    wait_req("req_seen_timeout");
    n = 0;
    while (mem_req && n < 60) begin
      @(negedge MCLK);
      n++;
    end
    check("timeout_req_cycles", 64'(n), 64'(24));
    n = 0;
    while (cart_VD_d && n < 10) begin
      @(negedge MCLK);
      n++;
    end
    check("timeout_vd_driven", 64'({cart_VD_d, cart_VD_o}), 64'({1'b0, 16'hFFFF}));
    check("late_err_pulses", 64'(late_cnt), 64'(1));
    release_bus("release_timeout");

    // Reset during WAIT with bank 3 reprogrammed
    reg_write(7'h7B, 16'h0015);
    start_read(23'h0C0000, {6'h15, 18'h00000});
    wait_req("req_seen_pre_reset");
    repeat (2) @(negedge MCLK);
    ext_reset = 1'b1;
    #1;
    check("reset_midcycle", 64'({mem_req, cart_VD_d}), 64'({1'b0, 1'b1}));
    @(negedge MCLK);
    bus_idle();
    @(negedge MCLK);
    ext_reset = 1'b0;
    ack_pulse(16'h9999);
    check("late_ack_ignored", 64'({mem_req, cart_VD_d, dbg_state}), 64'({1'b0, 1'b1, IDLE}));
    repeat (2) @(negedge MCLK);
    start_read(23'h0C0000, 24'h0C0000);
    rd_exp_q.push_back(16'hC0DE);
    wait_req("req_seen_bank3_identity");
    repeat (2) @(negedge MCLK);
    ack_read(16'hC0DE, lat);
    check("rd_latency_bank3", 64'(lat), 64'(2));
    release_bus("release_bank3");

    // Abandoned read, then a new cycle queued as pending
    start_read(23'h000200, 24'h000200);
    wait_req("req_seen_abandon");
    @(negedge MCLK);
    CE0 = 1'b1; CAS0 = 1'b1;
    repeat (2) @(negedge MCLK);
    VA = 23'h080300; CE0 = 1'b0; CAS0 = 1'b0;
    req_exp_q.push_back({24'h080300, 1'b0, 1'b0, 2'b11, 16'h0000});
    repeat (2) @(negedge MCLK);
    mem_rdata = 16'hDEAD; mem_ack = 1'b1;
    n_idle = -1; n_req = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge MCLK);
      if (i == 1) mem_ack = 1'b0;
      if (n_idle < 0 && dbg_state == IDLE) n_idle = i;
      else if (n_idle >= 0 && n_req < 0 && dbg_state == REQ) n_req = i;
    end
    check("pending_restart_next_cycle", 64'(n_req), 64'(n_idle + 1));
    rd_exp_q.push_back(16'h5A5A);
    wait_req("req_seen_pending");
    ack_read(16'h5A5A, lat);
    check("rd_latency_pending", 64'(lat), 64'(2));
    release_bus("release_pending");

    repeat (3) @(negedge MCLK);
    check("req_queue_drained", 64'(req_exp_q.size()), 64'(0));
    check("rd_queue_drained", 64'(rd_exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_cart_mapper.md
Name: md_cart_mapper

Overview:
- Cartridge-side bridge between the console 68k cart bus (VA/VD, CE0, CAS0, LWR/UWR, TIME) and an external word-wide memory port (ROM/SRAM backed by board memory).
- Successor to the fixed 21-bit passthrough cart hookup. Adds:
  - Parametrised bank width.
  - Eight-slot 512 KB bank mapper programmed via the /TIME register window.
  - Optional battery-SRAM window.
  - Request/acknowledge memory handshake with latency timeout.
- Sits at board level beside the 68k work RAM, in the MCLK domain.

Parameters:
- BANK_W, 6, bank register width; mem_addr width is BANK_W+18 words (default 32 MB ROM space).
- TIMEOUT, 24, MCLK cycles from mem_req to forced completion.
- SRAM_EN, 1, 1 = SRAM window logic present; 0 = bit tied low, mem_sram never asserts.

Ports:
- MCLK  in  1  system clock.
- ext_reset  in  1  asynchronous, active-high reset.
- VA  in  23  68k word address.
- VD_i  in  16  68k data bus (write data).
- CE0  in  1  cart chip enable, active low.
- CAS0  in  1  cart read strobe, active low.
- LWR  in  1  low-byte write strobe, active low.
- UWR  in  1  high-byte write strobe, active low.
- TIME  in  1  $A130xx register strobe, active low.
- cart_VD_o  out  16  read data to VD.
- cart_VD_d  out  1  VD drive disable (1 = tristated).
- mem_req  out  1  memory request, level.
- mem_we  out  1  request is a write.
- mem_be  out  2  byte enables {hi, lo}.
- mem_addr  out  BANK_W+18  word address.
- mem_sram  out  1  request targets SRAM.
- mem_wdata  out  16  write data.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  16  read data, valid with mem_ack.
- late_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async):
  - bank[i]=i for i=0..7; sram_on=0.
  - FSM=IDLE; pending=0.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_sram=0, mem_wdata=0.
  - cart_VD_o=16'hFFFF, cart_VD_d=1, late_err=0.
  - Reset mid-transaction drops mem_req immediately; a later mem_ack is ignored.
- Register writes: on the MCLK cycle where TIME=0 and LWR falls (registered edge):
  - VA[6:0]=7'h78 → sram_on=VD_i[0].
  - VA[6:0]=7'h79..7'h7F → bank[VA[2:0]]=VD_i[BANK_W-1:0].
  - bank[0] is read-only, fixed 0.
  - UWR-only writes are ignored.
- Address mapping:
  - slot=VA[20:18]; mem_addr={bank[slot],VA[17:0]}.
  - If sram_on and VA[20]=1: mem_sram=1 and mem_addr={0,VA[17:0]}.
- Cycle start:
  - sel=~CE0&~CAS0 (read) or ~CE0&(~LWR|~UWR) (write, SRAM window only).
  - Start = registered rising edge of sel.
  - ROM-window writes are ignored: no request, no error.
- FSM states:
  - IDLE: on start → REQ; latch address, mem_we, mem_be={~UWR,~LWR} (reads 2'b11), mem_wdata=VD_i.
  - REQ: assert mem_req; counter=0 → WAIT.
  - WAIT: mem_req held.
    - On mem_ack: drop mem_req; reads latch mem_rdata → HOLD.
    - If counter reaches TIMEOUT-1 without ack: drop mem_req; data=16'hFFFF; pulse late_err → HOLD.
  - HOLD: on a read with sel still asserted, cart_VD_d=0 and cart_VD_o=data. When sel deasserts, cart_VD_d=1 next cycle → IDLE.
- Read latency: cart_VD_d falls 2 cycles after mem_ack (ack capture plus output register).
- Boundary conditions:
  - sel deasserts during WAIT: handshake still completes; data is discarded and never driven.
  - New start while not IDLE: set pending (depth 1, further starts dropped). On return to IDLE, if pending and sel is still asserted, begin a new request next cycle; otherwise clear pending.
  - Register write coinciding with a bank access: the in-flight request keeps its latched address; the new bank value applies from the next start.
  - mem_ack outside WAIT is ignored.
  - TIMEOUT counter saturates and does not wrap.

Decomposition:
- Shared package md_cart_pkg:
  - Register offsets MAP_SRAM_REG=7'h78, MAP_BANK_BASE=7'h79.
  - SLOT_W=3, SLOT_WORDS_W=18.
  - FSM state enum {IDLE, REQ, WAIT, HOLD}.
- One natural sub-module, md_cart_bankregs: register file, write decode, address mapping. FSM/handshake stays in the top.

Test Plan:
- Reset, then read VA=23'h040000 (slot 1) with mem_ack after 3 cycles, rdata=16'h1234 → mem_addr=24'h040000, cart_VD_o=16'h1234, cart_VD_d=0 two cycles after ack, back to 1 after CAS0 rises.
- Write bank 7=6'h2A (TIME=0, VA[6:0]=7'h7F, VD_i=16'h002A), then read VA=23'h1C0005 → mem_addr={6'h2A,18'h00005}.
- Write reg 7'h78=1, then write VA=23'h100010 with UWR=1, LWR=0, VD_i=16'h00AB → mem_sram=1, mem_we=1, mem_be=2'b01, mem_wdata=16'h00AB. Same write with sram_on=0 → no mem_req.
- Read with mem_ack withheld → mem_req drops after 24 cycles, late_err single pulse, cart_VD_o=16'hFFFF driven while CAS0 low.
- Assert ext_reset during WAIT → mem_req=0 and cart_VD_d=1 immediately; late ack ignored; bank registers back to identity (bank 3 reads mem_addr 24'h0C0000 at VA=23'h0C0000).
- CAS0 rises before ack, then new cycle starts before ack → first data never driven; second request issued the cycle after returning to IDLE.
